// File: rtl/framebuffer_op_sequencer.sv
// Sequences commit/memset ops onto the colour and depth framebuffers after the pixel pipeline drains.
// Optional FB_SEQ_WATCHDOG_EN adds a per-phase WAIT timeout with a sticky error flag.
module framebuffer_op_sequencer #(
  parameter int DRAIN_QUIET    = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       aclk,
  input  logic       resetn,
  input  logic       s_op_valid,
  output logic       s_op_ready,
  input  logic [3:0] s_op_data,
  input  logic       rasterizerRunning,
  input  logic       pixelInPipeline,
  output logic       colorBufferApply,
  output logic       colorBufferCmdCommit,
  output logic       colorBufferCmdMemset,
  input  logic       colorBufferApplied,
  output logic       depthBufferApply,
  output logic       depthBufferCmdCommit,
  output logic       depthBufferCmdMemset,
  input  logic       depthBufferApplied,
  output logic       busy,
  output logic       opDone,
  output logic       error
);

  localparam int QW = $clog2(DRAIN_QUIET + 1);

  if (DRAIN_QUIET < 1 || TIMEOUT_CYCLES < 1) begin : gBadParam
    $error("DRAIN_QUIET and TIMEOUT_CYCLES must both be >= 1");
  end

  typedef enum logic [2:0] {IDLE, DRAIN, ISSUE, WAIT, DONE} state_t;

  state_t        state, nextState;
  logic [3:0]    opData;
  logic [QW-1:0] quietCnt;
  logic          phaseMemset;
  logic          colorDone, depthDone;

  logic selColor, selDepth, pipeIdle, quietReached;
  logic colorAck, depthAck, allDone, morePhase, degenerate, timeout;

  assign selColor     = opData[0];
  assign selDepth     = opData[1];
  assign pipeIdle     = !rasterizerRunning && !pixelInPipeline;
  assign quietReached = pipeIdle && (quietCnt == QW'(DRAIN_QUIET - 1));
  // applied only counts while the matching apply is still outstanding
  assign colorAck     = colorBufferApply && colorBufferApplied;
  assign depthAck     = depthBufferApply && depthBufferApplied;
  assign allDone      = (!selColor || colorDone || colorAck) &&
                        (!selDepth || depthDone || depthAck);
  assign morePhase    = !phaseMemset && opData[3];
  assign degenerate   = !(s_op_data[0] || s_op_data[1]) || !(s_op_data[2] || s_op_data[3]);

`ifdef FB_SEQ_WATCHDOG_EN
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_WIDTH-1:0] wdCnt;

  assign timeout = (state == WAIT) && (wdCnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      wdCnt <= '0;
      error <= 1'b0;
    end else begin
      if (state == ISSUE)
        wdCnt <= '0;
      else if (state == WAIT)
        wdCnt <= wdCnt + CNT_WIDTH'(1);
      if (state == IDLE && s_op_valid)
        error <= 1'b0;
      else if (timeout && !allDone)
        error <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (!resetn) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (s_op_valid) nextState = degenerate ? DONE : DRAIN;
      DRAIN: if (quietReached) nextState = ISSUE;
      ISSUE: nextState = WAIT;
      WAIT: begin
        if (allDone)      nextState = morePhase ? ISSUE : DONE;
        else if (timeout) nextState = DONE;
      end
      DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    s_op_ready = (state == IDLE);
    busy       = (state != IDLE);
    opDone     = (state == DONE);
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      opData               <= '0;
      quietCnt             <= '0;
      phaseMemset          <= 1'b0;
      colorDone            <= 1'b0;
      depthDone            <= 1'b0;
      colorBufferApply     <= 1'b0;
      colorBufferCmdCommit <= 1'b0;
      colorBufferCmdMemset <= 1'b0;
      depthBufferApply     <= 1'b0;
      depthBufferCmdCommit <= 1'b0;
      depthBufferCmdMemset <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_op_valid) begin
            opData   <= s_op_data;
            quietCnt <= '0;
          end
        end
        DRAIN: begin
          quietCnt <= pipeIdle ? quietCnt + QW'(1) : '0;
          if (quietReached)
            phaseMemset <= !opData[2];
        end
        ISSUE: begin
          colorDone            <= 1'b0;
          depthDone            <= 1'b0;
          colorBufferApply     <= selColor;
          colorBufferCmdCommit <= selColor && !phaseMemset;
          colorBufferCmdMemset <= selColor && phaseMemset;
          depthBufferApply     <= selDepth;
          depthBufferCmdCommit <= selDepth && !phaseMemset;
          depthBufferCmdMemset <= selDepth && phaseMemset;
        end
        WAIT: begin
          if (colorAck) begin
            colorDone            <= 1'b1;
            colorBufferApply     <= 1'b0;
            colorBufferCmdCommit <= 1'b0;
            colorBufferCmdMemset <= 1'b0;
          end
          if (depthAck) begin
            depthDone            <= 1'b1;
            depthBufferApply     <= 1'b0;
            depthBufferCmdCommit <= 1'b0;
            depthBufferCmdMemset <= 1'b0;
          end
          if (allDone && morePhase)
            phaseMemset <= 1'b1;
          // watchdog abort abandons whatever is still outstanding
          if (timeout && !allDone) begin
            colorBufferApply     <= 1'b0;
            colorBufferCmdCommit <= 1'b0;
            colorBufferCmdMemset <= 1'b0;
            depthBufferApply     <= 1'b0;
            depthBufferCmdCommit <= 1'b0;
            depthBufferCmdMemset <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_op_sequencer.sv
// Directed vector bench for framebuffer_op_sequencer; behavioural buffer responders ack after a set delay.
// Build with FB_SEQ_WATCHDOG_EN to exercise the timeout path (TIMEOUT_CYCLES=8).
module tb_framebuffer_op_sequencer;

`ifdef FB_SEQ_WATCHDOG_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 65535;
`endif

  logic       aclk = 1'b0;
  logic       resetn;
  logic       s_op_valid;
  logic       s_op_ready;
  logic [3:0] s_op_data;
  logic       rasterizerRunning, pixelInPipeline;
  logic       colorBufferApply, colorBufferCmdCommit, colorBufferCmdMemset, colorBufferApplied;
  logic       depthBufferApply, depthBufferCmdCommit, depthBufferCmdMemset, depthBufferApplied;
  logic       busy, opDone, error;

  always #5 aclk = ~aclk;

  framebuffer_op_sequencer #(.DRAIN_QUIET(2), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .aclk(aclk), .resetn(resetn),
    .s_op_valid(s_op_valid), .s_op_ready(s_op_ready), .s_op_data(s_op_data),
    .rasterizerRunning(rasterizerRunning), .pixelInPipeline(pixelInPipeline),
    .colorBufferApply(colorBufferApply), .colorBufferCmdCommit(colorBufferCmdCommit),
    .colorBufferCmdMemset(colorBufferCmdMemset), .colorBufferApplied(colorBufferApplied),
    .depthBufferApply(depthBufferApply), .depthBufferCmdCommit(depthBufferCmdCommit),
    .depthBufferCmdMemset(depthBufferCmdMemset), .depthBufferApplied(depthBufferApplied),
    .busy(busy), .opDone(opDone), .error(error)
  );

  // Buffer models: ack on the Nth cycle apply is high (0 = never); spur drives applied while apply is low.
  int cDelay = 0, dDelay = 0, spur = 0;
  int cCnt = 0, dCnt = 0;
  always @(negedge aclk) begin
    if (colorBufferApply) cCnt++; else cCnt = 0;
    if (depthBufferApply) dCnt++; else dCnt = 0;
    colorBufferApplied = colorBufferApply ? (cDelay != 0 && cCnt == cDelay) : (spur != 0);
    depthBufferApplied = depthBufferApply ? (dDelay != 0 && dCnt == dDelay) : (spur != 0);
  end

  typedef struct {
    logic [3:0] data;
    int cd, dd, spur;
    int expLat, expCC, expCM, expDC, expDM, expErr;
  } vec_t;

  vec_t vecs[12];
  bit   pat[7];
  int   tests = 0, fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int lat, cc, cm, dc, dm, bad, overlap, rdy, seen;
    lat = 0; cc = 0; cm = 0; dc = 0; dm = 0; bad = 0; overlap = 0; rdy = 0; seen = 0;
    cDelay = v.cd; dDelay = v.dd; spur = v.spur;
    @(negedge aclk);
    chk({tag, ".readyBefore"}, int'(s_op_ready), 1);
    s_op_valid = 1'b1; s_op_data = v.data;
    @(posedge aclk);
    #1 s_op_valid = 1'b0; s_op_data = 4'b0;
    for (int i = 0; i < 400 && seen == 0; i++) begin
      @(negedge aclk);
      lat++;
      cc += int'(colorBufferCmdCommit); cm += int'(colorBufferCmdMemset);
      dc += int'(depthBufferCmdCommit); dm += int'(depthBufferCmdMemset);
      if ((colorBufferApply && !(colorBufferCmdCommit ^ colorBufferCmdMemset)) ||
          (!colorBufferApply && (colorBufferCmdCommit || colorBufferCmdMemset))) bad++;
      if ((depthBufferApply && !(depthBufferCmdCommit ^ depthBufferCmdMemset)) ||
          (!depthBufferApply && (depthBufferCmdCommit || depthBufferCmdMemset))) bad++;
      if ((colorBufferCmdCommit || depthBufferCmdCommit) &&
          (colorBufferCmdMemset || depthBufferCmdMemset)) overlap++;
      if (s_op_ready) rdy++;
      if (opDone) seen = 1;
    end
    chk({tag, ".opDoneSeen"}, seen, 1);
    chk({tag, ".latency"}, lat, v.expLat);
    chk({tag, ".colorCommitCyc"}, cc, v.expCC);
    chk({tag, ".colorMemsetCyc"}, cm, v.expCM);
    chk({tag, ".depthCommitCyc"}, dc, v.expDC);
    chk({tag, ".depthMemsetCyc"}, dm, v.expDM);
    chk({tag, ".applyCmdCoherent"}, bad, 0);
    chk({tag, ".phaseOverlap"}, overlap, 0);
    chk({tag, ".readyDuringOp"}, rdy, 0);
    chk({tag, ".errorAtDone"}, int'(error), v.expErr);
    @(negedge aclk);
    chk({tag, ".opDoneSingle"}, int'(opDone), 0);
    chk({tag, ".readyAfter"}, int'(s_op_ready), 1);
    chk({tag, ".idleAfter"}, int'(busy), 0);
    chk({tag, ".applyAfter"}, int'(colorBufferApply) + int'(depthBufferApply), 0);
  endtask

  initial begin
    vec_t w;
    int seen;
    //           data     cd dd sp lat cc cm dc dm err
    vecs[0]  = '{4'b0101, 5, 0, 0, 9,  5, 0, 0, 0, 0};
    vecs[1]  = '{4'b1111, 5, 8, 0, 21, 5, 5, 8, 8, 0};
    vecs[2]  = '{4'b1010, 0, 3, 0, 7,  0, 0, 0, 3, 0};
    vecs[3]  = '{4'b0111, 2, 2, 0, 6,  2, 0, 2, 0, 0};
    vecs[4]  = '{4'b1001, 1, 0, 0, 5,  0, 1, 0, 0, 0};
    vecs[5]  = '{4'b0100, 0, 0, 0, 1,  0, 0, 0, 0, 0};
    vecs[6]  = '{4'b1100, 0, 0, 0, 1,  0, 0, 0, 0, 0};
    vecs[7]  = '{4'b0011, 0, 0, 0, 1,  0, 0, 0, 0, 0};
    vecs[8]  = '{4'b0000, 0, 0, 0, 1,  0, 0, 0, 0, 0};
    vecs[9]  = '{4'b0101, 3, 0, 1, 7,  3, 0, 0, 0, 0};
    vecs[10] = '{4'b1110, 0, 2, 0, 9,  0, 0, 2, 2, 0};
    vecs[11] = '{4'b1111, 6, 2, 0, 17, 6, 6, 2, 2, 0};
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset held with a pending request
    resetn = 1'b0; s_op_valid = 1'b1; s_op_data = 4'b0101;
    rasterizerRunning = 1'b0; pixelInPipeline = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk); #1;
      chk("reset.apply", int'(colorBufferApply) + int'(depthBufferApply), 0);
      chk("reset.busyDone", int'(busy) + int'(opDone) + int'(error), 0);
    end
    s_op_valid = 1'b0;
    @(negedge aclk) resetn = 1'b1;
    @(negedge aclk);
    chk("reset.readyAfter", int'(s_op_ready), 1);
    chk("reset.busyAfter", int'(busy), 0);

    for (int i = 0; i < 12; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Drain restarts whenever the fragment pipeline reports activity
    cDelay = 2; dDelay = 0; spur = 0;
    @(negedge aclk);
    s_op_valid = 1'b1; s_op_data = 4'b0101;
    @(posedge aclk);
    #1 s_op_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      pixelInPipeline = pat[i];
      @(negedge aclk);
      chk($sformatf("drain.applyCyc%0d", i + 1), int'(colorBufferApply), (i == 6) ? 1 : 0);
      @(posedge aclk); #1;
    end
    rasterizerRunning = 1'b0; pixelInPipeline = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge aclk);
      if (opDone) seen = 1;
    end
    chk("drain.opDoneSeen", seen, 1);

    // Reset while an apply is outstanding
    cDelay = 0;
    @(negedge aclk);
    s_op_valid = 1'b1; s_op_data = 4'b0101;
    @(posedge aclk);
    #1 s_op_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge aclk);
      if (colorBufferApply) seen = 1;
    end
    chk("midReset.applyRose", seen, 1);
    resetn = 1'b0;
    @(posedge aclk); #1;
    chk("midReset.applyLow", int'(colorBufferApply), 0);
    chk("midReset.idle", int'(busy), 0);
    chk("midReset.ready", int'(s_op_ready), 1);
    @(negedge aclk) resetn = 1'b1;
    run_op(vecs[0], "postReset");

`ifdef FB_SEQ_WATCHDOG_EN
    // Colour never acks: 8 WAIT cycles then abort with sticky error, cleared by the next accept
    w = '{4'b0101, 0, 0, 0, 12, 8, 0, 0, 0, 1};
    run_op(w, "wdTimeout");
    chk("wdTimeout.errorSticky", int'(error), 1);
    run_op(vecs[9], "wdRecover");
    w = '{4'b1111, 0, 3, 0, 12, 8, 0, 3, 0, 1};
    run_op(w, "wdPartial");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
